// File: rtl/rs_gbx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_gbx_pkg
// Description : Shared types and configuration helpers for the FIFO read-side
//               width-down gearbox.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_gbx_pkg;

  typedef enum logic {
    GBX_IDLE  = 1'b0,
    GBX_SHIFT = 1'b1
  } gbx_state_t;

  function automatic int gbx_ratio(input int datasize, input int out_width);
    return datasize / out_width;
  endfunction

  function automatic bit gbx_cfg_ok(input int datasize, input int out_width);
    return (out_width > 0) && (datasize >= out_width) && ((datasize % out_width) == 0);
  endfunction

  function automatic int gbx_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_fifo_rd_gearbox_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_fifo_rd_gearbox_if
// Description : FIFO read port plus narrow valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_fifo_rd_gearbox_if #(
  parameter int DATASIZE  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 fifo_empty;
  logic [DATASIZE-1:0]  fifo_rd_data;
  logic                 fifo_rd;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;

  // master is the gearbox itself; slave is the FIFO/consumer environment
  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd, out_data, out_valid, out_last
  );
endinterface
`default_nettype wire

// File: rtl/rs_gbx_chunk_mux.sv
`default_nettype none
// ============================================================================
// Module      : rs_gbx_chunk_mux
// Description : Selects one OUT_WIDTH chunk of the held word. LSB-first unless
//               RS_GBX_MSB_FIRST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_gbx_chunk_mux
  import rs_gbx_pkg::*;
#(
  parameter int DATASIZE  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  wire logic [DATASIZE-1:0]                                     i_hold,
  input  wire logic [gbx_cnt_w(gbx_ratio(DATASIZE, OUT_WIDTH))-1:0]    i_cnt,
  output logic      [OUT_WIDTH-1:0]                                    o_chunk
);

  localparam int c_RATIO = gbx_ratio(DATASIZE, OUT_WIDTH);
  localparam int c_CNT_W = gbx_cnt_w(c_RATIO);

  always_comb begin
    o_chunk = '0;
    for (int i = 0; i < c_RATIO; i++) begin
      if (i_cnt == c_CNT_W'(i)) begin
`ifdef RS_GBX_MSB_FIRST_EN
        o_chunk = i_hold[(c_RATIO-1-i)*OUT_WIDTH +: OUT_WIDTH];
`else
        o_chunk = i_hold[i*OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_fifo_rd_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : rs_fifo_rd_gearbox
// Description : Pops words from a first-word-fall-through FIFO and streams
//               them out as RATIO narrow chunks with no inter-word bubble.
//               Chunk order: LSB-first, MSB-first with RS_GBX_MSB_FIRST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_fifo_rd_gearbox
  import rs_gbx_pkg::*;
#(
  parameter int DATASIZE  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  wire logic            rclk,
  input  wire logic            rd_reset_n,
  input  wire logic            flush,
  rs_fifo_rd_gearbox_if.master gbx
);

  localparam int c_RATIO = gbx_ratio(DATASIZE, OUT_WIDTH);
  localparam int c_CNT_W = gbx_cnt_w(c_RATIO);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_RATIO - 1);

  generate
    if (!gbx_cfg_ok(DATASIZE, OUT_WIDTH)) begin : g_cfg_check
      $error("rs_fifo_rd_gearbox: DATASIZE must be a multiple of OUT_WIDTH");
    end
  endgenerate

  gbx_state_t            r_state;
  gbx_state_t            w_state_nxt;
  logic [c_CNT_W-1:0]    r_chunk_cnt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic [DATASIZE-1:0]   r_hold;
  logic [OUT_WIDTH-1:0]  w_chunk;
  logic                  w_out_valid;
  logic                  w_at_last;
  logic                  w_accept;
  logic                  w_last_acc;
  logic                  w_fifo_rd;

  assign w_out_valid = (r_state == GBX_SHIFT);
  assign w_at_last   = (r_chunk_cnt == c_LAST_CNT);
  assign w_accept    = w_out_valid & gbx.out_ready;
  assign w_last_acc  = w_accept & w_at_last;
  // Refill either from idle or on the very edge the last chunk leaves
  assign w_fifo_rd   = rd_reset_n & ~flush & ~gbx.fifo_empty &
                       ((r_state == GBX_IDLE) | w_last_acc);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_chunk_cnt;
    if (flush) begin
      w_state_nxt = GBX_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_fifo_rd) begin
      w_state_nxt = GBX_SHIFT;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        GBX_SHIFT: begin
          if (w_last_acc) begin
            w_state_nxt = GBX_IDLE;
          end else if (w_accept) begin
            w_cnt_nxt = r_chunk_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = GBX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (!rd_reset_n) begin
      r_state     <= GBX_IDLE;
      r_chunk_cnt <= '0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_chunk_cnt <= w_cnt_nxt;
      if (w_fifo_rd) begin
        r_hold <= gbx.fifo_rd_data;
      end
    end
  end

  rs_gbx_chunk_mux #(
    .DATASIZE  (DATASIZE),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_chunk_mux (
    .i_hold  (r_hold),
    .i_cnt   (r_chunk_cnt),
    .o_chunk (w_chunk)
  );

  assign gbx.fifo_rd   = w_fifo_rd;
  assign gbx.out_valid = w_out_valid;
  assign gbx.out_last  = w_out_valid & w_at_last;
  assign gbx.out_data  = w_chunk;

endmodule
`default_nettype wire

// File: tb/tb_rs_fifo_rd_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_fifo_rd_gearbox
// Description : Self-checking bench; queue-based FIFO and chunk-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_fifo_rd_gearbox;

  localparam int DATASIZE  = 32;
  localparam int OUT_WIDTH = 8;
  localparam int RATIO     = DATASIZE / OUT_WIDTH;

  logic rclk;
  logic rd_reset_n;
  logic flush;

  rs_fifo_rd_gearbox_if #(.DATASIZE(DATASIZE), .OUT_WIDTH(OUT_WIDTH)) bus ();

  rs_fifo_rd_gearbox #(
    .DATASIZE  (DATASIZE),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .rclk       (rclk),
    .rd_reset_n (rd_reset_n),
    .flush      (flush),
    .gbx        (bus.master)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [DATASIZE-1:0]  fifo_q[$];
  logic [OUT_WIDTH-1:0] cur_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Split a word into the chunk sequence the consumer must see
  task automatic load_word(input logic [DATASIZE-1:0] w);
    logic [OUT_WIDTH-1:0] c;
    cur_q.delete();
    for (int i = 0; i < RATIO; i++) begin
`ifdef RS_GBX_MSB_FIRST_EN
      c = w[(RATIO-1-i)*OUT_WIDTH +: OUT_WIDTH];
`else
      c = w[i*OUT_WIDTH +: OUT_WIDTH];
`endif
      cur_q.push_back(c);
    end
  endtask

  task automatic run_cycle(input bit rst_n, input bit stall, input bit rdy, input bit fl);
    bit exp_rd;
    bit exp_valid;
    bit empty;
    @(negedge rclk);
    empty            = stall || (fifo_q.size() == 0);
    rd_reset_n       = rst_n;
    flush            = fl;
    bus.out_ready    = rdy;
    bus.fifo_empty   = empty;
    bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : DATASIZE'($urandom);
    #1;
    exp_valid = (cur_q.size() != 0);
    exp_rd    = rst_n && !fl && !empty &&
                ((cur_q.size() == 0) || (rdy && cur_q.size() == 1));
    check("fifo_rd", 32'(bus.fifo_rd), 32'(exp_rd));
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("out_data", 32'(bus.out_data), 32'(cur_q[0]));
      check("out_last", 32'(bus.out_last), 32'(cur_q.size() == 1));
    end else begin
      check("out_last_idle", 32'(bus.out_last), 32'd0);
    end
    if (bus.fifo_rd && empty) check("rd_while_empty", 32'd1, 32'd0);
    if (!rst_n || fl) begin
      cur_q.delete();
    end else begin
      if (exp_valid && rdy) void'(cur_q.pop_front());
      if (exp_rd) begin
        load_word(fifo_q[0]);
        void'(fifo_q.pop_front());
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || cur_q.size() != 0) && n < budget) begin
      run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      n++;
    end
    check("drain_done", 32'(fifo_q.size() + cur_q.size()), 32'd0);
    fifo_q.delete();
    cur_q.delete();
  endtask

  initial begin
    rd_reset_n       = 1'b0;
    flush            = 1'b0;
    bus.out_ready    = 1'b0;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;

    // 1: reset with a non-empty FIFO, then first cycle after release pops
    fifo_q.push_back(32'h12345678);
    @(posedge rclk);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_out_data", 32'(bus.out_data), 32'd0);
    end
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("first_pop_after_reset", 32'(bus.fifo_rd), 32'd1);
    drain(20);

    // 2: single word, then idle with empty FIFO
    fifo_q.push_back(32'hA1B2C3D4);
    drain(20);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);

    // 3: back-to-back words, no bubble
    fifo_q.push_back(32'h03020100);
    fifo_q.push_back(32'h07060504);
    drain(20);

    // 4: backpressure holding the second chunk
    fifo_q.push_back(32'hA1B2C3D4);
    fifo_q.push_back(32'h55667788);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    drain(20);

    // 5: flush right after the first chunk is accepted
    fifo_q.push_back(32'hA1B2C3D4);
    fifo_q.push_back(32'h11223344);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check("flush_valid_cleared", 32'(cur_q.size()), 32'd0);
    drain(20);

    // 6: random empty/ready/flush patterns
    for (int i = 0; i < 3000; i++) fifo_q.push_back(DATASIZE'($urandom));
    for (int n = 0; n < 60000 && (fifo_q.size() != 0 || cur_q.size() != 0); n++) begin
      run_cycle(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 299) == 0);
    end
    drain(100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
